// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared definitions for the gate-model BIST controller.
//   state_e     - controller FSM states
//   LFSR taps   - x^20 + x^17 + 1 (feedback from bits 19 and 16)
//   MISR taps   - x^10 + x^7 + 1  (feedback from bits 9 and 6)
//   SEED_SUBST  - LFSR start value used when the requested seed is zero
package gate_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int unsigned LFSR_TAP_A = 19;
  localparam int unsigned LFSR_TAP_B = 16;
  localparam int unsigned MISR_TAP_A = 9;
  localparam int unsigned MISR_TAP_B = 6;
  localparam int unsigned SEED_SUBST = 1;

endpackage

// File: rtl/bist_lfsr_misr.sv
// bist_lfsr_misr: pattern LFSR plus response MISR.
//   clk, rst_n   - clock, asynchronous active-low reset
//   load         - load LFSR from seed (zero seed replaced by SEED_SUBST)
//   clear        - clear the MISR
//   step         - advance LFSR and absorb rsp_i into the MISR
//   seed, rsp_i  - LFSR start value, response to compress
//   lfsr_o       - current LFSR register
//   misr_o       - current MISR register
//   misr_nxt_o   - value the MISR takes at the coming edge
module bist_lfsr_misr
  import gate_bist_pkg::*;
#(
  parameter int unsigned PAT_W = 20,
  parameter int unsigned RSP_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic             step,
  input  logic [PAT_W-1:0] seed,
  input  logic [RSP_W-1:0] rsp_i,
  output logic [PAT_W-1:0] lfsr_o,
  output logic [RSP_W-1:0] misr_o,
  output logic [RSP_W-1:0] misr_nxt_o
);

  logic [PAT_W-1:0] lfsr_q, lfsr_d;
  logic [RSP_W-1:0] misr_q, misr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    misr_d = misr_q;
    if (load) begin
      lfsr_d = (seed == '0) ? PAT_W'(SEED_SUBST) : seed;
    end else if (step) begin
      lfsr_d = {lfsr_q[PAT_W-2:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
    end
    if (clear) begin
      misr_d = '0;
    end else if (step) begin
      misr_d = {misr_q[RSP_W-2:0] ^ rsp_i[RSP_W-1:1],
                misr_q[MISR_TAP_A] ^ misr_q[MISR_TAP_B] ^ rsp_i[0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= '0;
      misr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      misr_q <= misr_d;
    end
  end

  assign lfsr_o     = lfsr_q;
  assign misr_o     = misr_q;
  assign misr_nxt_o = misr_d;

endmodule

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: runs n_pat LFSR patterns into a gate model, compresses the
// responses in a MISR and compares the final signature with exp_sig.
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - begin a run (accepted only in IDLE)
//   seed, n_pat - LFSR start value and pattern count, captured at start
//   exp_sig     - golden signature
//   pat_o       - pattern to the gate model (bit 0 = N1)
//   rsp_i       - gate model response
//   busy        - LOAD or RUN
//   done        - one-cycle end-of-run pulse
//   signature   - MISR contents
//   pass        - signature matched exp_sig; valid from done until next run
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int unsigned PAT_W = 20,
  parameter int unsigned RSP_W = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] seed,
  input  logic [CNT_W-1:0] n_pat,
  input  logic [RSP_W-1:0] exp_sig,
  output logic [PAT_W-1:0] pat_o,
  input  logic [RSP_W-1:0] rsp_i,
  output logic             busy,
  output logic             done,
  output logic [RSP_W-1:0] signature,
  output logic             pass
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_pat_q, n_pat_d;
  logic [PAT_W-1:0] seed_q, seed_d;
  logic             pass_q, pass_d;
  logic             load, clear, step;
  logic [RSP_W-1:0] misr_nxt;

  bist_lfsr_misr #(
    .PAT_W (PAT_W),
    .RSP_W (RSP_W)
  ) u_lfsr_misr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .clear      (clear),
    .step       (step),
    .seed       (seed_q),
    .rsp_i      (rsp_i),
    .lfsr_o     (pat_o),
    .misr_o     (signature),
    .misr_nxt_o (misr_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_pat_d = n_pat_q;
    seed_d  = seed_q;
    pass_d  = pass_q;
    load    = 1'b0;
    clear   = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Inputs are captured at the accepting edge so LOAD uses stable copies.
        if (start) begin
          state_d = ST_LOAD;
          n_pat_d = n_pat;
          seed_d  = seed;
        end
      end
      ST_LOAD: begin
        load    = 1'b1;
        clear   = 1'b1;
        cnt_d   = '0;
        pass_d  = 1'b0;
        state_d = (n_pat_q == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == n_pat_q - 1'b1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Compare against the MISR value being written on the edge into DONE so
    // pass is already valid during the done cycle.
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      pass_d = (misr_nxt == exp_sig);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      n_pat_q <= '0;
      seed_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_pat_q <= n_pat_d;
      seed_q  <= seed_d;
      pass_q  <= pass_d;
    end
  end

  assign busy = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign pass = pass_q;

endmodule
